// File: rtl/elixirchip_es1_spu_pkg.sv
// Shared definitions for the SPU arithmetic stages.
// Holds the signed clamp helper and pipeline limits.
package elixirchip_es1_spu_pkg;

   localparam int MIN_LATENCY = 2;
   localparam int SAT_BITS    = 128;

   // Clamp a wide signed value into the signed range of 'width' bits.
   function automatic logic signed [SAT_BITS-1:0] sat_signed(
      input logic signed [SAT_BITS-1:0] value,
      input int                         width
   );
      logic signed [SAT_BITS-1:0] one;
      logic signed [SAT_BITS-1:0] hi;
      logic signed [SAT_BITS-1:0] lo;
      one    = '0;
      one[0] = 1'b1;
      hi     = (one <<< (width - 1)) - one;
      lo     = ~hi;
      if (width >= SAT_BITS) return value;
      if (value > hi) return hi;
      if (value < lo) return lo;
      return value;
   endfunction

endpackage

// File: rtl/elixirchip_es1_spu_delay.sv
// Clock-enabled delay line with asynchronous reset.
// Carries whole output bundles through the trailing pipeline stages.
module elixirchip_es1_spu_delay #(
   parameter int               WIDTH       = 1,
   parameter int               STAGES      = 1,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0,
   parameter                   DEVICE      = "RTL"
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             cke,
   input  logic [WIDTH-1:0] s_data,
   output logic [WIDTH-1:0] m_data
);

   if (DEVICE == "RTL") begin : g_rtl
      logic [WIDTH-1:0] pipe_q [STAGES];

      // Shift the bundle one stage per enabled clock.
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            for (int i = 0; i < STAGES; i++) pipe_q[i] <= RESET_VALUE;
         end else if (cke) begin
            pipe_q[0] <= s_data;
            for (int i = 1; i < STAGES; i++) pipe_q[i] <= pipe_q[i-1];
         end
      end

      assign m_data = pipe_q[STAGES-1];
   end else begin : g_dev
      (* shreg_extract = "no" *)
      logic [WIDTH-1:0] pipe_q [STAGES];

      // Same chain; kept out of shift-register primitives on real devices.
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            for (int i = 0; i < STAGES; i++) pipe_q[i] <= RESET_VALUE;
         end else if (cke) begin
            pipe_q[0] <= s_data;
            for (int i = 1; i < STAGES; i++) pipe_q[i] <= pipe_q[i-1];
         end
      end

      assign m_data = pipe_q[STAGES-1];
   end

endmodule

// File: rtl/elixirchip_es1_spu_op_accsu.sv
// Signed accumulator following the SPU multiplier stage.
// Accumulates, shifts, then saturates or wraps to the output width.
module elixirchip_es1_spu_op_accsu
   import elixirchip_es1_spu_pkg::*;
#(
   parameter int                     LATENCY     = 2,
   parameter int                     S_DATA_BITS = 16,
   parameter int                     ACC_BITS    = 48,
   parameter int                     M_DATA_BITS = 32,
   parameter int                     DATA_SHIFT  = 0,
   parameter bit                     SATURATE    = 1'b1,
   parameter logic [M_DATA_BITS-1:0] CLEAR_DATA  = '0,
   parameter                         DEVICE      = "RTL",
   parameter                         SIMULATION  = "false",
   parameter                         DEBUG       = "false"
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   cke,
   input  logic [S_DATA_BITS-1:0] s_data,
   input  logic                   s_first,
   input  logic                   s_clear,
   input  logic                   s_valid,
   output logic [M_DATA_BITS-1:0] m_data,
   output logic                   m_valid,
   output logic                   m_overflow
);

   if (SIMULATION == "true" &&
       (LATENCY < MIN_LATENCY || ACC_BITS < S_DATA_BITS)) begin : g_bad_cfg
      $error("elixirchip_es1_spu_op_accsu: illegal LATENCY or ACC_BITS");
   end

   logic signed [ACC_BITS-1:0] acc_q;
   logic signed [ACC_BITS-1:0] acc_view;
   logic signed [ACC_BITS-1:0] s_ext;
   logic signed [ACC_BITS-1:0] sum;
   logic                       add_ovf;
   logic                       ovf_q;
   logic                       valid_q;
   logic                       clear_q;

   assign s_ext   = ACC_BITS'($signed(s_data));
   assign sum     = acc_q + s_ext;
   assign add_ovf = (acc_q[ACC_BITS-1] == s_ext[ACC_BITS-1]) &&
                    (sum[ACC_BITS-1] != acc_q[ACC_BITS-1]);

   // Stage 1: clear beats restart, restart beats add.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc_q   <= '0;
         ovf_q   <= 1'b0;
         valid_q <= 1'b0;
         clear_q <= 1'b0;
      end else if (cke) begin
         valid_q <= s_valid;
         clear_q <= s_clear;
         if (s_clear) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
         end else if (s_valid && s_first) begin
            acc_q <= s_ext;
            ovf_q <= 1'b0;
         end else if (s_valid) begin
            acc_q <= sum;
            ovf_q <= ovf_q | add_ovf;
         end
      end
   end

   if (DEBUG == "true") begin : g_debug
      (* mark_debug = "true" *)
      logic signed [ACC_BITS-1:0] dbg_acc;
      assign dbg_acc  = acc_q;
      assign acc_view = dbg_acc;
   end else begin : g_nodebug
      assign acc_view = acc_q;
   end

   logic signed [ACC_BITS-1:0] sh;
   logic signed [SAT_BITS-1:0] wide;
   logic signed [SAT_BITS-1:0] clamped;
   logic                       sat;

   assign sh      = acc_view >>> DATA_SHIFT;
   assign wide    = SAT_BITS'(sh);
   assign clamped = SATURATE ? sat_signed(wide, M_DATA_BITS) : wide;
   assign sat     = clamped != wide;

   logic [M_DATA_BITS-1:0] m2_data;
   logic                   m2_valid;
   logic                   m2_ovf;

   // Stage 2: register the shifted, range-limited sample.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m2_data  <= CLEAR_DATA;
         m2_valid <= 1'b0;
         m2_ovf   <= 1'b0;
      end else if (cke) begin
         if (clear_q) begin
            m2_data  <= CLEAR_DATA;
            m2_valid <= 1'b0;
            m2_ovf   <= 1'b0;
         end else begin
            m2_data  <= clamped[M_DATA_BITS-1:0];
            m2_valid <= valid_q;
            m2_ovf   <= ovf_q | sat;
         end
      end
   end

   if (LATENCY <= MIN_LATENCY) begin : g_direct
      assign m_data     = m2_data;
      assign m_valid    = m2_valid;
      assign m_overflow = m2_ovf;
   end else begin : g_delay
      logic [M_DATA_BITS+1:0] dly_out;

      elixirchip_es1_spu_delay #(
         .WIDTH       (M_DATA_BITS + 2),
         .STAGES      (LATENCY - MIN_LATENCY),
         .RESET_VALUE ({CLEAR_DATA, 2'b00}),
         .DEVICE      (DEVICE)
      ) u_delay (
         .clk     (clk),
         .reset_n (reset_n),
         .cke     (cke),
         .s_data  ({m2_data, m2_valid, m2_ovf}),
         .m_data  (dly_out)
      );

      assign {m_data, m_valid, m_overflow} = dly_out;
   end

endmodule
